keypad_hex_entry: RTL
=====================

# keypad_hex_entry

Scans a 4x4 matrix keypad (row-driven, column-sensed), debounces presses, and turns each accepted key into a 4-bit hex code. Accepted nibbles shift into a 32-bit entry register from the low end. This is the input counterpart of the multiplexed 8-digit hex display. The entry register feeds the display data bus and the processor's input port.

## Interface
Parameters:
- SCAN_DIV, 1000: clock cycles per row period. Minimum 4.
- DEBOUNCE_SCANS, 4: consecutive matching samples required to accept a press or a release. Minimum 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; one clock; asynchronous, active-low.
- col  in  4  keypad columns, active-low, externally pulled up, asynchronous to clk.
- row  out  4  keypad row drive, active-low, exactly one row low at any time.
- clear  in  1  synchronous; zeroes the entry register.
- key_valid  out  1  one-cycle pulse per accepted key.
- key_code  out  4  code of the last accepted key; held between pulses.
- data  out  32  entry register.
- bksp  in  1  present only with HEX_ENTRY_BKSP_EN.

## Operation
- col passes through a 2-flop synchronizer before any use.
- A row counter cycles 0..SCAN_DIV-1. Sampling:
  - The synchronized col is sampled when the counter equals SCAN_DIV-1 (the sample strobe).
  - row r drives row[r]=0.
  - Key code = {row index[1:0], column index[1:0]}, so row 2 col 1 gives 0x9.
- A sample is a "single hit" when exactly one col bit is 0. Zero low bits, or two or more, is "no key". Ghosting and multi-press are never accepted.
- FSM states:
  - SCAN: on each strobe with no key, advance row 0→1→2→3→0. On a single hit, latch the candidate code, stop advancing, set the match count to 1, and go to DEBOUNCE.
  - DEBOUNCE: row is held. On each strobe:
    - Same single hit: increment the count.
    - Anything else: return to SCAN and advance the row.
    - Count reaching DEBOUNCE_SCANS: go to ACCEPT. With DEBOUNCE_SCANS=1, ACCEPT follows the first hit directly.
  - ACCEPT, one cycle:
    - key_valid=1 and key_code=candidate.
    - data <= {data[27:0], candidate}.
    - Go to RELEASE.
  - RELEASE: row is held. Each strobe with col=4'hF increments the release count; any other sample resets it to 0. After DEBOUNCE_SCANS consecutive all-high samples, return to SCAN and advance the row. A held key therefore produces exactly one key_valid; there is no auto-repeat.
- Priority on data in one cycle: clear > ACCEPT shift > bksp.
  - If clear coincides with ACCEPT: data=0, but key_valid still pulses and key_code still updates.
- data wraps silently. The ninth entered nibble pushes the oldest out of bits [31:28].

## Timing
- Reset values:
  - row=4'b1110, key_valid=0, key_code=0, data=0.
  - FSM=SCAN, row counter=0, match and release counts=0, synchronizer flops=1.
- Synchronizer latency is 2 cycles. The strobe sees col as it was 2 cycles earlier.
- key_valid asserts on the cycle after the accepting strobe. data and key_code update on that same edge.
- Press-to-valid latency is at most (4+DEBOUNCE_SCANS)·SCAN_DIV+3 cycles.
- clear and bksp act on the edge where they are sampled high. Level-held inputs repeat their action every cycle.
- Asserting rst_n low mid-debounce or mid-release abandons the press without a key_valid. All outputs return to their reset values immediately, without waiting for clk.

## Configuration
- HEX_ENTRY_BKSP_EN defined:
  - The bksp port exists.
  - A cycle with bksp=1 performs data <= {4'h0, data[31:4]}, unless clear or ACCEPT occurs in the same cycle, in which case bksp is ignored.
- HEX_ENTRY_BKSP_EN undefined: no bksp port and no backspace logic.

## Test plan
Bench parameters: SCAN_DIV=4, DEBOUNCE_SCANS=3.
1. Hold col=4'b1101 only while row=4'b1011 (row 2, col 1) until release, then release → exactly one key_valid with key_code=0x9, data=0x00000009, scan resumes at row 3.
2. Enter keys 1,2,3,4,5,6,7,8,9 → data=0x23456789 (0x1 shifted out), nine key_valid pulses.
3. Bounce: single hit on row 0 col 0 for 2 strobes, then col=4'hF, repeated → no key_valid, scan keeps advancing.
4. Press two columns on the same row (col=4'b1100) → no key_valid. Press row 1 col 3 alone → key_code=0x7.
5. Assert clear on the ACCEPT cycle with data=0x000000AB → data=0, key_valid=1. Drop rst_n in RELEASE → row=4'b1110, data=0 asynchronously.
6. With HEX_ENTRY_BKSP_EN: data=0x00001234, bksp pulse → 0x00000123. bksp coincident with ACCEPT of 0x5 → data=0x00001235.

Source files
------------

// File: rtl/keypad_hex_entry.sv
// keypad_hex_entry: scans a 4x4 row-driven / column-sensed keypad, debounces
// presses and releases, and shifts each accepted key's hex code into a 32-bit
// entry register from the low end.
// Optional feature: define HEX_ENTRY_BKSP_EN to add the bksp port and the
// backspace (shift-right) action on the entry register.
module keypad_hex_entry #(
    parameter int unsigned SCAN_DIV       = 1000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  col,
    output logic [3:0]  row,
    input  logic        clear,
`ifdef HEX_ENTRY_BKSP_EN
    input  logic        bksp,
`endif
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [31:0] data
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DB_W  = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_SCANS - 1);

    typedef enum logic [1:0] {
        S_SCAN     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_ACCEPT   = 2'd2,
        S_RELEASE  = 2'd3
    } state_t;

    state_t          r_state;
    logic [3:0]      r_col_s1;
    logic [3:0]      r_col_s2;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]      r_row_idx;
    logic [3:0]      r_row;
    logic [3:0]      r_cand;
    logic [DB_W-1:0] r_match;
    logic [DB_W-1:0] r_rel;
    logic            r_key_valid;
    logic [3:0]      r_key_code;
    logic [31:0]     r_data;

    logic            w_strobe;
    logic            w_hit;
    logic [1:0]      w_col_idx;
    logic [3:0]      w_code;

    // Two-flop synchronizer for the asynchronous column inputs (idle high)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col_s1 <= 4'hF;
            r_col_s2 <= 4'hF;
        end else begin
            r_col_s1 <= col;
            r_col_s2 <= r_col_s1;
        end
    end

    // Free-running row-period counter; its last count is the sample strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_strobe = (r_cnt == CNT_LAST);

    // Single-hit decode: exactly one column low; anything else is "no key"
    always_comb begin
        w_hit     = 1'b0;
        w_col_idx = 2'd0;
        case (r_col_s2)
            4'b1110: begin w_hit = 1'b1; w_col_idx = 2'd0; end
            4'b1101: begin w_hit = 1'b1; w_col_idx = 2'd1; end
            4'b1011: begin w_hit = 1'b1; w_col_idx = 2'd2; end
            4'b0111: begin w_hit = 1'b1; w_col_idx = 2'd3; end
            default: begin w_hit = 1'b0; w_col_idx = 2'd0; end
        endcase
    end

    assign w_code = {r_row_idx, w_col_idx};

    // Scan / debounce / accept / release-wait state machine with row drive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_SCAN;
            r_row_idx   <= 2'd0;
            r_row       <= 4'b1110;
            r_cand      <= 4'h0;
            r_match     <= '0;
            r_rel       <= '0;
            r_key_valid <= 1'b0;
            r_key_code  <= 4'h0;
        end else begin
            r_key_valid <= 1'b0;
            case (r_state)
                S_SCAN: begin
                    if (w_strobe) begin
                        if (w_hit) begin
                            r_cand  <= w_code;
                            r_match <= DB_W'(1);
                            if (DEBOUNCE_SCANS <= 1) begin
                                r_state <= S_ACCEPT;
                            end else begin
                                r_state <= S_DEBOUNCE;
                            end
                        end else begin
                            r_row_idx <= r_row_idx + 2'd1;
                            r_row     <= {r_row[2:0], r_row[3]};
                        end
                    end
                end
                S_DEBOUNCE: begin
                    if (w_strobe) begin
                        if (w_hit && (w_code == r_cand)) begin
                            r_match <= r_match + DB_W'(1);
                            if (r_match == DB_LAST) begin
                                r_state <= S_ACCEPT;
                            end
                        end else begin
                            r_match   <= '0;
                            r_state   <= S_SCAN;
                            r_row_idx <= r_row_idx + 2'd1;
                            r_row     <= {r_row[2:0], r_row[3]};
                        end
                    end
                end
                S_ACCEPT: begin
                    r_key_valid <= 1'b1;
                    r_key_code  <= r_cand;
                    r_match     <= '0;
                    r_rel       <= '0;
                    r_state     <= S_RELEASE;
                end
                S_RELEASE: begin
                    if (w_strobe) begin
                        if (r_col_s2 == 4'hF) begin
                            if (r_rel == DB_LAST) begin
                                r_rel     <= '0;
                                r_state   <= S_SCAN;
                                r_row_idx <= r_row_idx + 2'd1;
                                r_row     <= {r_row[2:0], r_row[3]};
                            end else begin
                                r_rel <= r_rel + DB_W'(1);
                            end
                        end else begin
                            r_rel <= '0;
                        end
                    end
                end
                default: begin
                    r_state <= S_SCAN;
                end
            endcase
        end
    end

    // Entry register: clear beats the accept shift, which beats backspace
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= 32'h0;
        end else if (clear) begin
            r_data <= 32'h0;
        end else if (r_state == S_ACCEPT) begin
            r_data <= {r_data[27:0], r_cand};
`ifdef HEX_ENTRY_BKSP_EN
        end else if (bksp) begin
            r_data <= {4'h0, r_data[31:4]};
`endif
        end
    end

    assign row       = r_row;
    assign key_valid = r_key_valid;
    assign key_code  = r_key_code;
    assign data      = r_data;

endmodule
